// File: rtl/dct2d_pkg.sv
// Shared constants, state encoding and packing helpers for the 8x8 2D DCT controller.
// Packing is MSB-first: element 0 occupies the most significant field of a row/column.
package dct2d_pkg;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 18;
  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned ROW_W = IN_W * N;
  localparam int unsigned COL_W = OUT_W * N;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_COL   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Packed 8-element sample vector; index N-1 holds element 0.
  typedef logic [N-1:0][IN_W-1:0] row_t;

  // Packed 8-element coefficient vector; index N-1 holds element 0.
  typedef logic [N-1:0][OUT_W-1:0] col_t;

  // Element k of a sample vector under MSB-first packing.
  function automatic logic [IN_W-1:0] row_get(input row_t r, input logic [IDX_W-1:0] k);
    return r[IDX_W'(N - 1) - k];
  endfunction

  // Element k of a coefficient vector under MSB-first packing.
  function automatic logic [OUT_W-1:0] col_get(input col_t c, input logic [IDX_W-1:0] k);
    return c[IDX_W'(N - 1) - k];
  endfunction

endpackage

// File: rtl/rnd_shift_sat.sv
// Round-to-nearest arithmetic right shift of one core coefficient, clamped to a signed
// 8-bit sample.
//   i_coef     : signed OUT_W-bit coefficient from the core
//   o_sample_c : signed IN_W-bit rounded/saturated sample (combinational)
module rnd_shift_sat
  import dct2d_pkg::*;
#(
  parameter int unsigned SHIFT = 9
) (
  input  logic signed [OUT_W-1:0] i_coef,
  output logic signed [IN_W-1:0]  o_sample_c
);

  // One guard bit keeps coefficient + rounding constant from overflowing.
  localparam int unsigned SUM_W = OUT_W + 1;
  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(1 << (SHIFT - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (IN_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX - SUM_W'(1);

  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_shr;

  assign w_sum = $signed({i_coef[OUT_W-1], i_coef}) + RND;
  assign w_shr = w_sum >>> SHIFT;

  // Clamp to the signed sample range.
  always_comb begin
    o_sample_c = w_shr[IN_W-1:0];
    if (w_shr > SAT_MAX) begin
      o_sample_c = SAT_MAX[IN_W-1:0];
    end else if (w_shr < SAT_MIN) begin
      o_sample_c = SAT_MIN[IN_W-1:0];
    end
  end

endmodule

// File: rtl/dct8x8_2d_ctrl.sv
// Sequences an external combinational 8-point DCT core through a full 8x8 forward 2D DCT.
// Row pass: 8 input rows go through the core, are rounded/shifted/saturated to 8 bits and
// stored in a transpose buffer. Column pass: the 8 buffer columns go through the same core
// and leave as 18-bit coefficient columns on a valid/ready stream.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : row sample handshake, in_data = 8 x 8-bit samples
//   out_valid/out_ready   : coefficient column handshake, out_data = 8 x 18-bit coeffs
//   out_col, out_last     : horizontal frequency index of out_data, last-column flag
//   core_x, core_y        : shared core input vector / core output vector
//   busy                  : block in progress
module dct8x8_2d_ctrl
  import dct2d_pkg::*;
#(
  parameter int unsigned SHIFT = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COL_W-1:0] out_data,
  output logic [IDX_W-1:0] out_col,
  output logic             out_last,
  output logic [ROW_W-1:0] core_x,
  input  logic [COL_W-1:0] core_y,
  output logic             busy
);

  state_e           r_state;
  logic [IDX_W-1:0] r_row_cnt;
  logic [IDX_W-1:0] r_col_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [COL_W-1:0] r_out_data;
  logic [IDX_W-1:0] r_out_col;
  logic             r_out_last;
  row_t             r_buf [N];

  row_t             w_row_sat;
  row_t             w_col_vec;
  logic [IDX_W-1:0] w_col_sel;
  logic             w_in_fire;
  logic             w_col_cap;

  // Row-pass post-processing of each core output element.
  for (genvar k = 0; k < int'(N); k++) begin : g_rss
    rnd_shift_sat #(
      .SHIFT (SHIFT)
    ) u_rss (
      .i_coef     (col_get(core_y, IDX_W'(k))),
      .o_sample_c (w_row_sat[N-1-k])
    );
  end

  // Buffer column gather; DRAIN keeps presenting column 7 so core_x stays deterministic.
  always_comb begin
    w_col_vec = '0;
    w_col_sel = (r_state == ST_DRAIN) ? IDX_W'(N - 1) : r_col_cnt;
    for (int r = 0; r < int'(N); r++) begin
      w_col_vec[IDX_W'(N - 1 - r)] = row_get(r_buf[r], w_col_sel);
    end
  end

  assign w_in_fire = in_valid && r_in_ready;
  assign w_col_cap = (r_state == ST_COL) && (!r_out_valid || out_ready);

  // Control FSM, transpose buffer and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_row_cnt   <= '0;
      r_col_cnt   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_col   <= '0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_buf[r_row_cnt] <= w_row_sat;
            r_row_cnt        <= r_row_cnt + IDX_W'(1);
            if (r_row_cnt == IDX_W'(N - 1)) begin
              r_state    <= ST_COL;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_COL: begin
          if (w_col_cap) begin
            r_out_valid <= 1'b1;
            r_out_data  <= core_y;
            r_out_col   <= r_col_cnt;
            r_out_last  <= (r_col_cnt == IDX_W'(N - 1));
            r_col_cnt   <= r_col_cnt + IDX_W'(1);
            if (r_col_cnt == IDX_W'(N - 1)) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Last column must be taken before the next block may start.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_LOAD;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_LOAD;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_col   = r_out_col;
  assign out_last  = r_out_last;
  assign core_x    = (r_state == ST_LOAD) ? in_data : w_col_vec;
  assign busy      = (r_state != ST_LOAD) || (r_row_cnt != '0);

endmodule

// File: tb/tb_dct8x8_2d_ctrl.sv
// Directed bench for dct8x8_2d_ctrl: two instances (SHIFT=9 and SHIFT=8) run in lockstep on
// shared stimulus, each with its own behavioural core. Expected columns are computed from the
// DCT matrix definition and queued when a block's last row is sent.
module tb_dct8x8_2d_ctrl;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [63:0]  in_data   = '0;

  logic         in_ready9, out_valid9, out_last9, busy9;
  logic [143:0] out_data9, core_y9;
  logic [63:0]  core_x9;
  logic [2:0]   out_col9;

  logic         in_ready8, out_valid8, out_last8, busy8;
  logic [143:0] out_data8, core_y8;
  logic [63:0]  core_x8;
  logic [2:0]   out_col8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int blk [8][8];
  int dct_c [8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}
  };

  typedef struct packed {
    logic [2:0]   col;
    logic [143:0] d9;
    logic [143:0] d8;
  } exp_t;

  exp_t         sb [$];
  exp_t         mon_e;
  logic [143:0] last_col0_9 = '0;
  logic [143:0] last_col0_8 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8-point core: y[v] = sum_n C[v][n] * x[n].
  function automatic logic [143:0] core_fn(input logic [63:0] x);
    logic [143:0] y;
    int acc;
    y = '0;
    for (int v = 0; v < 8; v++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) begin
        acc += dct_c[v][n] * int'($signed(x[63-8*n -: 8]));
      end
      y[143-18*v -: 18] = 18'(acc);
    end
    return y;
  endfunction

  assign core_y9 = core_fn(core_x9);
  assign core_y8 = core_fn(core_x8);

  dct8x8_2d_ctrl #(.SHIFT(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready9), .in_data(in_data),
    .out_valid(out_valid9), .out_ready(out_ready), .out_data(out_data9), .out_col(out_col9),
    .out_last(out_last9), .core_x(core_x9), .core_y(core_y9), .busy(busy9)
  );

  dct8x8_2d_ctrl #(.SHIFT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_col(out_col8),
    .out_last(out_last8), .core_x(core_x8), .core_y(core_y8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference 2D transform of blk, column c, with row-pass shift s.
  function automatic logic [143:0] model_col(input int s, input int c);
    int t [8][8];
    int acc;
    logic [143:0] y;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++) acc += dct_c[k][n] * blk[r][n];
        acc = (acc + (1 << (s - 1))) >>> s;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        t[r][k] = acc;
      end
    end
    y = '0;
    for (int v = 0; v < 8; v++) begin
      acc = 0;
      for (int r = 0; r < 8; r++) acc += dct_c[v][r] * t[r][c];
      y[143-18*v -: 18] = 18'(acc);
    end
    return y;
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      e.col = 3'(c);
      e.d9  = model_col(9, c);
      e.d8  = model_col(8, c);
      sb.push_back(e);
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < 8; r++) for (int n = 0; n < 8; n++) blk[r][n] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++) for (int n = 0; n < 8; n++) blk[r][n] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Send the first nrows rows of blk; keep leaves in_valid high afterwards.
  task automatic send_block(input int nrows, input bit keep, output int t0);
    int w;
    t0 = 0;
    for (int r = 0; r < nrows; r++) begin
      for (int n = 0; n < 8; n++) in_data[63-8*n -: 8] = 8'(blk[r][n]);
      in_valid = 1'b1;
      w = 0;
      while (!in_ready9 && w < 100) begin
        @(posedge clk); #1;
        w++;
      end
      check("in_ready_wait", 144'(w < 100), 144'(1));
      if (r == 0) t0 = cyc;
      @(posedge clk); #1;
    end
    if (nrows == 8) push_expected();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || busy9) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_wait", 144'(w < 300), 144'(1));
  endtask

  // Scoreboard monitor: compares every accepted column of both instances.
  always @(negedge clk) begin
    if (rst_n && out_valid9 && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_column", 144'(out_col9), 144'(8));
      end else begin
        mon_e = sb.pop_front();
        check("out_col_s9", 144'(out_col9), 144'(mon_e.col));
        check("out_last_s9", 144'(out_last9), 144'(mon_e.col == 3'd7));
        check("out_data_s9", out_data9, mon_e.d9);
        check("out_valid_s8", 144'(out_valid8), 144'(1));
        check("out_col_s8", 144'(out_col8), 144'(mon_e.col));
        check("out_last_s8", 144'(out_last8), 144'(mon_e.col == 3'd7));
        check("out_data_s8", out_data8, mon_e.d8);
        if (mon_e.col == 3'd0) begin
          last_col0_9 = out_data9;
          last_col0_8 = out_data8;
        end
      end
    end
  end

  initial begin
    int t0, t1, w;
    logic [143:0] hold;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 144'(out_valid9), 144'(0));
    check("rst_out_data", out_data9, 144'(0));
    check("rst_out_col", 144'(out_col9), 144'(0));
    check("rst_out_last", 144'(out_last9), 144'(0));
    check("rst_in_ready", 144'(in_ready9), 144'(1));
    check("rst_busy", 144'(busy9), 144'(0));
    check("rst_out_valid_s8", 144'(out_valid8), 144'(0));
    check("rst_in_ready_s8", 144'(in_ready8), 144'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero block, then constant 16 back to back: latency and block period
    fill_const(0);
    send_block(8, 1'b1, t0);
    check("lat_valid_c1", 144'(out_valid9), 144'(0));
    check("lat_busy", 144'(busy9), 144'(1));
    @(posedge clk); #1;
    check("lat_valid_c2", 144'(out_valid9), 144'(1));
    check("lat_col_c2", 144'(out_col9), 144'(0));
    check("col_in_ready", 144'(in_ready9), 144'(0));
    fill_const(16);
    send_block(8, 1'b0, t1);
    check("block_period", 144'(t1 - t0), 144'(17));
    wait_drain();
    check("const16_col0", last_col0_9, {18'd8192, 126'd0});

    // All -128 block
    fill_const(-128);
    send_block(8, 1'b0, t0);
    wait_drain();
    check("neg128_col0_s9", last_col0_9, {18'h30000, 126'd0});
    check("neg128_col0_s8", last_col0_8, {18'h30000, 126'd0});

    // Constant 127: SHIFT=8 row DC rounds to 254 and saturates to 127
    fill_const(127);
    send_block(8, 1'b0, t0);
    wait_drain();
    check("sat127_col0_s8", last_col0_8, {18'd65024, 126'd0});
    check("c127_col0_s9", last_col0_9, {18'd65024, 126'd0});

    // Backpressure on column 2
    fill_rand();
    send_block(8, 1'b0, t0);
    w = 0;
    while (!(out_valid9 && out_col9 == 3'd2) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("bp_reach_col2", 144'(w < 100), 144'(1));
    out_ready = 1'b0;
    hold = out_data9;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_valid", 144'(out_valid9), 144'(1));
      check("bp_col", 144'(out_col9), 144'(2));
      check("bp_data", out_data9, hold);
      check("bp_in_ready", 144'(in_ready9), 144'(0));
    end
    out_ready = 1'b1;
    wait_drain();

    // Reset after 5 rows, then a fresh block
    fill_rand();
    send_block(5, 1'b0, t0);
    check("partial_busy", 144'(busy9), 144'(1));
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("rst1_busy", 144'(busy9), 144'(0));
    check("rst1_in_ready", 144'(in_ready9), 144'(1));
    check("rst1_out_valid", 144'(out_valid9), 144'(0));
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand();
    send_block(8, 1'b0, t0);
    wait_drain();

    // Reset while column 3 is pending, then a fresh block
    fill_rand();
    send_block(8, 1'b0, t0);
    w = 0;
    while (!(out_valid9 && out_col9 == 3'd3) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("rst2_reach_col3", 144'(w < 100), 144'(1));
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("rst2_out_valid", 144'(out_valid9), 144'(0));
    check("rst2_out_data", out_data9, 144'(0));
    check("rst2_out_col", 144'(out_col9), 144'(0));
    check("rst2_out_last", 144'(out_last9), 144'(0));
    check("rst2_busy", 144'(busy9), 144'(0));
    check("rst2_out_valid_s8", 144'(out_valid8), 144'(0));
    @(negedge clk);
    rst_n = 1'b1;
    fill_rand();
    send_block(8, 1'b0, t0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
